// File: rtl/md_issue_ctrl_pkg.sv
// Shared HI/LO constants: op codes, mf read selects and unit latencies.
// The multiply/divide unit and its pipeline-side requester both import this.
package md_issue_ctrl_pkg;

    typedef enum logic [2:0] {
        HILO_NONE  = 3'd0,
        HILO_MULT  = 3'd1,
        HILO_MULTU = 3'd2,
        HILO_DIV   = 3'd3,
        HILO_DIVU  = 3'd4,
        HILO_MTHI  = 3'd5,
        HILO_MTLO  = 3'd6
    } hilo_op_e;

    localparam logic [1:0] MF_NONE = 2'd0;
    localparam logic [1:0] MF_LO   = 2'd1;
    localparam logic [1:0] MF_HI   = 2'd2;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int REM_W       = 4;

    function automatic logic hilo_is_mul(input logic [2:0] op);
        return (op == HILO_MULT) || (op == HILO_MULTU);
    endfunction

    function automatic logic hilo_is_div(input logic [2:0] op);
        return (op == HILO_DIV) || (op == HILO_DIVU);
    endfunction

    // Any real op; code 7 falls through as none.
    function automatic logic hilo_is_op(input logic [2:0] op);
        return hilo_is_mul(op) || hilo_is_div(op) ||
               (op == HILO_MTHI) || (op == HILO_MTLO);
    endfunction

endpackage

// File: rtl/md_proto_mon.sv
// Shadow latency counter that checks the unit's busy protocol cycle-exactly.
// Ports: clk, reset, md_op (issued op), md_busy; rem_nz (run), proto_err (sticky).
module md_proto_mon
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] md_op,
    input  logic       md_busy,
    output logic       rem_nz,
    output logic       proto_err
);

    logic [REM_W-1:0] rem;
    logic             issued_q;
    logic             is_mul;
    logic             is_div;
    logic             early;
    logic             late;
    logic             into;

    always_comb begin
        is_mul = hilo_is_mul(md_op);
        is_div = hilo_is_div(md_op);
        rem_nz = (rem != '0);
        early  = rem_nz && !md_busy;
        // issued_q also waives the first edge after reset.
        late   = !rem_nz && md_busy && !issued_q;
        into   = hilo_is_op(md_op) && (rem_nz || md_busy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem       <= '0;
            issued_q  <= 1'b1;
            proto_err <= 1'b0;
        end else begin
            if (early || late || into)
                proto_err <= 1'b1;
            issued_q <= is_mul || is_div;
            if (!rem_nz && is_mul)
                rem <= REM_W'(MUL_LAT);
            else if (!rem_nz && is_div)
                rem <= REM_W'(DIV_LAT);
            else if (rem_nz)
                rem <= rem - 1'b1;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Pipeline-side requester for the HI/LO multiply/divide unit.
// Ports: E-stage op in, md_op out, stall_d, mf read mux, proto_err, stall_cnt.
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_md_use,
    input  logic             e_valid,
    input  logic [2:0]       e_op,
    input  logic [1:0]       e_mf_sel,
    input  logic             md_busy,
    input  logic             md_start,
    input  logic [31:0]      md_hi,
    input  logic [31:0]      md_lo,
    output logic [2:0]       md_op,
    output logic             stall_d,
    output logic [31:0]      e_md_rdata,
    output logic             proto_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic rem_nz;

    md_proto_mon #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mon (
        .clk       (clk),
        .reset     (reset),
        .md_op     (md_op),
        .md_busy   (md_busy),
        .rem_nz    (rem_nz),
        .proto_err (proto_err)
    );

    always_comb begin
        md_op = (e_valid && !reset) ? e_op : HILO_NONE;
        // rem_nz holds the stall even if busy drops early.
        stall_d = !reset && d_md_use &&
                  (md_start || md_busy || rem_nz);
        case (e_mf_sel)
            MF_HI:   e_md_rdata = md_hi;
            MF_LO:   e_md_rdata = md_lo;
            default: e_md_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall_d && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed and random checks of md_issue_ctrl against a cycle-indexed model.
// The bench also plays the multiply/divide unit, with fault knobs on busy.
module tb_md_issue_ctrl;

    localparam int MUL_L   = 5;
    localparam int DIV_L   = 10;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             d_md_use = 1'b0;
    logic             e_valid = 1'b0;
    logic [2:0]       e_op = 3'd0;
    logic [1:0]       e_mf_sel = 2'd0;
    logic             md_busy = 1'b0;
    logic             md_start;
    logic [31:0]      md_hi = 32'd0;
    logic [31:0]      md_lo = 32'd0;
    logic [2:0]       md_op;
    logic             stall_d;
    logic [31:0]      e_md_rdata;
    logic             proto_err;
    logic [CNT_W-1:0] stall_cnt;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Model state, indexed by absolute cycle number k.
    int   k         = 0;
    int   free_at   = 0;
    int   cnt_m     = 0;
    logic err_m     = 1'b0;
    logic waive_m   = 1'b1;
    // Unit model and its fault knobs.
    int   unit_end  = 0;
    int   drop_from = 1 << 30;
    int   extra     = 0;

    always #5 clk = ~clk;

    assign md_start = (md_op >= 3'd1) && (md_op <= 3'd4);

    md_issue_ctrl #(
        .MUL_LAT (MUL_L),
        .DIV_LAT (DIV_L),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_md_use   (d_md_use),
        .e_valid    (e_valid),
        .e_op       (e_op),
        .e_mf_sel   (e_mf_sel),
        .md_busy    (md_busy),
        .md_start   (md_start),
        .md_hi      (md_hi),
        .md_lo      (md_lo),
        .md_op      (md_op),
        .stall_d    (stall_d),
        .e_md_rdata (e_md_rdata),
        .proto_err  (proto_err),
        .stall_cnt  (stall_cnt)
    );

    function automatic int lat_of(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MUL_L;
        if (op == 3'd3 || op == 3'd4) return DIV_L;
        return 0;
    endfunction

    function automatic int rem_now();
        return (free_at > k) ? free_at - k : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op,
                         input logic use_d, input logic [1:0] sel);
        e_valid  = v;
        e_op     = op;
        d_md_use = use_d;
        e_mf_sel = sel;
    endtask

    // One clock cycle: present busy, check outputs, advance the model.
    task automatic cycle();
        logic [2:0]  x_op;
        logic        x_stall;
        logic [31:0] x_rd;
        int          rem;
        int          lat;
        md_busy = (k < unit_end) && (k < drop_from);
        #1;
        rem     = rem_now();
        x_op    = (e_valid && !reset) ? e_op : 3'd0;
        x_stall = !reset && d_md_use &&
                  (lat_of(x_op) != 0 || md_busy || rem != 0);
        x_rd    = (e_mf_sel == 2'd2) ? md_hi :
                  (e_mf_sel == 2'd1) ? md_lo : 32'd0;
        check("md_op", 32'(md_op), 32'(x_op));
        check("stall_d", 32'(stall_d), 32'(x_stall));
        check("e_md_rdata", e_md_rdata, x_rd);
        check("proto_err", 32'(proto_err), 32'(err_m));
        check("stall_cnt", 32'(stall_cnt), 32'(cnt_m));
        @(posedge clk);
        lat = lat_of(x_op);
        if (reset) begin
            free_at  = 0;
            cnt_m    = 0;
            err_m    = 1'b0;
            waive_m  = 1'b1;
            unit_end = 0;
        end else begin
            if (x_stall && cnt_m < CNT_MAX) cnt_m++;
            if (rem != 0 && !md_busy) err_m = 1'b1;
            if (rem == 0 && md_busy && !waive_m) err_m = 1'b1;
            if (x_op >= 3'd1 && x_op <= 3'd6 && (rem != 0 || md_busy))
                err_m = 1'b1;
            waive_m = (lat != 0);
            if (lat != 0 && rem == 0) free_at = k + 1 + lat;
            if (lat != 0 && k >= unit_end) unit_end = k + 1 + lat + extra;
        end
        k++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 2'd0);
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // mult: stall from start through T0+5, six stall cycles.
        drive(1'b1, 3'd1, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (6) cycle();
        check("mult_cnt", 32'(stall_cnt), 32'd6);
        check("mult_err", 32'(proto_err), 32'd0);

        // div with mflo waiting: 11 stall cycles, then LO=3 for 7/2.
        do_reset();
        md_hi = 32'd1;
        md_lo = 32'd3;
        drive(1'b1, 3'd3, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (10) cycle();
        check("div_cnt", 32'(stall_cnt), 32'd11);
        drive(1'b1, 3'd0, 1'b1, 2'd1);
        #1;
        check("mflo", e_md_rdata, 32'h3);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd2);
        cycle();

        // Bubble carrying a mult code issues nothing.
        drive(1'b0, 3'd1, 1'b1, 2'd0);
        #1;
        check("bubble_op", 32'(md_op), 32'd0);
        repeat (3) cycle();
        check("bubble_cnt", 32'(stall_cnt), 32'd11);

        // Stall counter saturates.
        do_reset();
        drive(1'b1, 3'd3, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (10) cycle();
        drive(1'b1, 3'd4, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (11) cycle();
        check("cnt_sat", 32'(stall_cnt), 32'd15);

        // Busy dropped early at T0+3.
        do_reset();
        drop_from = k + 3;
        drive(1'b1, 3'd1, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (8) cycle();
        check("early_err", 32'(proto_err), 32'd1);
        drop_from = 1 << 30;

        // Issue into a busy unit.
        do_reset();
        drive(1'b1, 3'd1, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd2, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (6) cycle();
        check("into_err", 32'(proto_err), 32'd1);

        // Busy extended one cycle late.
        do_reset();
        extra = 1;
        drive(1'b1, 3'd2, 1'b0, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b0, 2'd0);
        repeat (8) cycle();
        check("late_err", 32'(proto_err), 32'd1);
        extra = 0;

        // Reset mid-div at T0+4, then a clean mult.
        do_reset();
        drive(1'b1, 3'd3, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (3) cycle();
        reset = 1'b1;
        drive(1'b1, 3'd1, 1'b1, 2'd2);
        #1;
        check("rst_op", 32'(md_op), 32'd0);
        check("rst_stall", 32'(stall_d), 32'd0);
        cycle();
        reset = 1'b0;
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_err", 32'(proto_err), 32'd0);
        drive(1'b1, 3'd1, 1'b1, 2'd0);
        cycle();
        drive(1'b1, 3'd0, 1'b1, 2'd0);
        repeat (6) cycle();
        check("post_rst_err", 32'(proto_err), 32'd0);
        check("post_rst_cnt", 32'(stall_cnt), 32'd6);

        // Random legal traffic: ops only reach an idle unit.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [2:0] op;
            logic       v;
            v = ($urandom_range(0, 9) < 7);
            if (v && (rem_now() != 0 || k < unit_end))
                op = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd7;
            else
                op = 3'($urandom_range(0, 7));
            drive(v, op, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)));
            md_hi = $urandom;
            md_lo = $urandom;
            cycle();
        end
        check("rand_legal_err", 32'(proto_err), 32'd0);

        // Random unconstrained traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            reset = ($urandom_range(0, 19) == 0);
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            md_hi = $urandom;
            md_lo = $urandom;
            cycle();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
